scanline_reader: RTL and testbench

Read side of the ping-pong line buffer. The sprite compositor fills the inactive bank and signals `line_ready`. This block owns the active bank and swaps banks at line boundaries. It walks `rd_addr` in step with `DrawX`/`DrawY` and delivers a pixel-aligned 4-bit color index to the palette stage. A missing line is reported as an underrun and that line is filled with the background index.

---
 rtl/scanline_reader.sv | 147 ++++++++++++++
 tb/tb_scanline_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/scanline_reader.sv
// Read side of the ping-pong line buffer: owns the active bank, swaps at line boundaries, emits aligned indices.
// Latency 2 clocks from the pixel_en sampling edge to pix_*; accepts one pixel per clock, no backpressure.
// Optional SCANLINE_UNDERRUN_CNT_EN adds a saturating 16-bit underrun_count output.
module scanline_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int IDX_W    = 4
) (
  input  logic             Clk50,
  input  logic             Reset_n,
  input  logic             pixel_en,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             blank,
  input  logic             line_ready,
  output logic             line_ack,
  output logic             rd_bank,
  output logic [9:0]       rd_addr,
  input  logic [IDX_W-1:0] rd_data,
  input  logic [IDX_W-1:0] bg_index,
  output logic [IDX_W-1:0] pix_index,
  output logic             pix_valid,
  output logic             pix_blank,
  output logic             underrun
`ifdef SCANLINE_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_count
`endif
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    UNDERRUN = 2'd2,
    VBLANK   = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic       pending, pending_nxt;
  logic       swap, urun;
  logic       line_evt;
  logic [9:0] next_row;

  logic s1_vld, s1_blank, s1_inr, s1_act;
  logic s2_vld, s2_blank, s2_inr, s2_act;

  assign line_evt = pixel_en && (DrawX == H_LAST);
  assign next_row = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;

  // A line_ready coinciding with the line event counts as already pending.
  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    urun      = 1'b0;
    if (line_evt) begin
      if (next_row >= V_ACT) begin
        state_nxt = VBLANK;
      end else if (pending || line_ready) begin
        swap      = 1'b1;
        state_nxt = ACTIVE;
      end else begin
        urun      = 1'b1;
        state_nxt = UNDERRUN;
      end
    end
    pending_nxt = swap ? 1'b0 : (pending || line_ready);
  end

  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      pending  <= 1'b0;
      rd_bank  <= 1'b0;
      line_ack <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      rd_bank  <= rd_bank ^ swap;
      line_ack <= swap;
      underrun <= urun;
    end
  end

  // Stage 1 issues the RAM address; stage 2 waits out the RAM read.
  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_addr  <= 10'd0;
      s1_vld   <= 1'b0;
      s1_blank <= 1'b0;
      s1_inr   <= 1'b0;
      s1_act   <= 1'b0;
      s2_vld   <= 1'b0;
      s2_blank <= 1'b0;
      s2_inr   <= 1'b0;
      s2_act   <= 1'b0;
    end else begin
      s1_vld <= pixel_en;
      if (pixel_en) begin
        rd_addr  <= (DrawX < H_ACT) ? DrawX : 10'd0;
        s1_blank <= blank;
        s1_inr   <= (DrawX < H_ACT);
        s1_act   <= (state == ACTIVE);
      end
      s2_vld   <= s1_vld;
      s2_blank <= s1_blank;
      s2_inr   <= s1_inr;
      s2_act   <= s1_act;
    end
  end

  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_index <= '0;
      pix_valid <= 1'b0;
      pix_blank <= 1'b0;
    end else begin
      pix_valid <= s2_vld;
      if (s2_vld) begin
        pix_blank <= s2_blank;
        if (!s2_blank)
          pix_index <= '0;
        else if (s2_act && s2_inr)
          pix_index <= rd_data;
        else
          pix_index <= bg_index;
      end
    end
  end

`ifdef SCANLINE_UNDERRUN_CNT_EN
  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n)
      underrun_count <= 16'd0;
    else if (underrun && (underrun_count != 16'hFFFF))
      underrun_count <= underrun_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_scanline_reader.sv
// Directed bench for scanline_reader; the RAM model returns addr[3:0] + (bank ? 5 : 0).
module tb_scanline_reader;

  logic       Clk50 = 1'b0;
  logic       Reset_n;
  logic       pixel_en;
  logic [9:0] DrawX, DrawY;
  logic       blank, line_ready;
  logic       line_ack, rd_bank, pix_valid, pix_blank, underrun;
  logic [9:0] rd_addr;
  logic [3:0] rd_data, bg_index, pix_index;
`ifdef SCANLINE_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  int passed = 0;
  int total  = 0;

  always #5 Clk50 = ~Clk50;

  always @(posedge Clk50) rd_data <= rd_addr[3:0] + (rd_bank ? 4'h5 : 4'h0);

  scanline_reader dut (
    .Clk50(Clk50), .Reset_n(Reset_n), .pixel_en(pixel_en), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .line_ready(line_ready), .line_ack(line_ack), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rd_data(rd_data), .bg_index(bg_index), .pix_index(pix_index),
    .pix_valid(pix_valid), .pix_blank(pix_blank), .underrun(underrun)
`ifdef SCANLINE_UNDERRUN_CNT_EN
    , .underrun_count(underrun_count)
`endif
  );

  task automatic tick();
    @(posedge Clk50); #1;
  endtask

  // Presents one pixel; returns 1 time unit after its sampling edge.
  task automatic px(input logic [9:0] x, input logic [9:0] y, input logic b);
    DrawX = x; DrawY = y; blank = b; pixel_en = 1'b1;
    tick();
    pixel_en = 1'b0;
  endtask

  task automatic pulse_ready();
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; pixel_en = 1'b0; DrawX = 0; DrawY = 0; blank = 1'b0;
    line_ready = 1'b0; bg_index = 4'h3;
    tick(); tick();
    total++; if ({line_ack, rd_bank, underrun, pix_valid, pix_blank} !== 5'b0)
      $display("FAIL reset_flags got %b exp 00000", {line_ack, rd_bank, underrun, pix_valid, pix_blank}); else passed++;
    total++; if (rd_addr !== 10'd0) $display("FAIL reset_addr got %0d exp 0", rd_addr); else passed++;
    total++; if (pix_index !== 4'h0) $display("FAIL reset_index got %0h exp 0", pix_index); else passed++;
    total++; if (dut.state !== 2'd0) $display("FAIL reset_state got %0d exp 0", dut.state); else passed++;
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_bg();
    px(10'd5, 10'd10, 1'b1);
    tick(); tick();
    total++; if (pix_valid !== 1'b1 || pix_index !== 4'h3)
      $display("FAIL idle_bg got v=%b idx=%0h exp v=1 idx=3", pix_valid, pix_index); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL idle_no_underrun got %b exp 0", underrun); else passed++;
  endtask

  task automatic test_swap();
    pulse_ready();
    px(10'd799, 10'd10, 1'b1);
    total++; if (rd_bank !== 1'b1 || line_ack !== 1'b1)
      $display("FAIL swap_edge got bank=%b ack=%b exp bank=1 ack=1", rd_bank, line_ack); else passed++;
    tick();
    total++; if (line_ack !== 1'b0) $display("FAIL swap_ack_width got %b exp 0", line_ack); else passed++;
    px(10'd5, 10'd11, 1'b1);
    total++; if (rd_addr !== 10'd5) $display("FAIL swap_addr got %0d exp 5", rd_addr); else passed++;
    tick();
    total++; if (pix_valid !== 1'b0) $display("FAIL latency_early got %b exp 0", pix_valid); else passed++;
    tick();
    total++; if (pix_valid !== 1'b1 || pix_index !== 4'hA || pix_blank !== 1'b1)
      $display("FAIL swap_data got v=%b idx=%0h bl=%b exp v=1 idx=a bl=1", pix_valid, pix_index, pix_blank); else passed++;
    tick();
    total++; if (pix_valid !== 1'b0) $display("FAIL valid_width got %b exp 0", pix_valid); else passed++;
    px(10'd639, 10'd11, 1'b1); tick(); tick();
    total++; if (pix_index !== 4'h4) $display("FAIL last_in_range got %0h exp 4", pix_index); else passed++;
    px(10'd640, 10'd11, 1'b1);
    total++; if (rd_addr !== 10'd0) $display("FAIL oor_addr got %0d exp 0", rd_addr); else passed++;
    tick(); tick();
    total++; if (pix_index !== 4'h3) $display("FAIL oor_bg got %0h exp 3", pix_index); else passed++;
    px(10'd700, 10'd11, 1'b0); tick(); tick();
    total++; if (pix_index !== 4'h0 || pix_blank !== 1'b0)
      $display("FAIL blank_zero got idx=%0h bl=%b exp idx=0 bl=0", pix_index, pix_blank); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin pixel_en = 1'b1; DrawX = 10'(i); DrawY = 10'd11; blank = 1'b1; end
      else pixel_en = 1'b0;
      tick();
      if (i >= 2) begin
        exp = 4'(i - 2) + 4'h5;
        total++; if (pix_valid !== 1'b1 || pix_index !== exp)
          $display("FAIL b2b_px%0d got v=%b idx=%0h exp v=1 idx=%0h", i - 2, pix_valid, pix_index, exp); else passed++;
      end
    end
    tick();
    total++; if (pix_valid !== 1'b0) $display("FAIL b2b_tail got %b exp 0", pix_valid); else passed++;
  endtask

  task automatic test_underrun();
    int bad;
    px(10'd799, 10'd20, 1'b1);
    total++; if (underrun !== 1'b1 || rd_bank !== 1'b1 || line_ack !== 1'b0)
      $display("FAIL underrun_edge got u=%b bank=%b ack=%b exp u=1 bank=1 ack=0", underrun, rd_bank, line_ack); else passed++;
    tick();
    total++; if (underrun !== 1'b0) $display("FAIL underrun_width got %b exp 0", underrun); else passed++;
    bad = 0;
    for (int x = 0; x < 640; x++) begin
      px(10'(x), 10'd21, 1'b1); tick(); tick();
      if (pix_index !== 4'h3) bad++;
    end
    total++; if (bad != 0) $display("FAIL underrun_row got %0d bad pixels exp 0", bad); else passed++;
  endtask

  task automatic test_vblank();
    pulse_ready();
    px(10'd799, 10'd479, 1'b1);
    total++; if (underrun !== 1'b0 || line_ack !== 1'b0 || rd_bank !== 1'b1)
      $display("FAIL vblank_entry got u=%b ack=%b bank=%b exp 0 0 1", underrun, line_ack, rd_bank); else passed++;
    total++; if (dut.state !== 2'd3) $display("FAIL vblank_state got %0d exp 3", dut.state); else passed++;
    pulse_ready();
    px(10'd5, 10'd500, 1'b0); tick(); tick();
    total++; if (pix_index !== 4'h0) $display("FAIL vblank_index got %0h exp 0", pix_index); else passed++;
    px(10'd799, 10'd524, 1'b1);
    total++; if (rd_bank !== 1'b0 || line_ack !== 1'b1 || dut.state !== 2'd1)
      $display("FAIL frame_swap got bank=%b ack=%b st=%0d exp 0 1 1", rd_bank, line_ack, dut.state); else passed++;
    px(10'd5, 10'd0, 1'b1); tick(); tick();
    total++; if (pix_index !== 4'h5) $display("FAIL row0_data got %0h exp 5", pix_index); else passed++;
  endtask

  task automatic test_same_cycle();
    line_ready = 1'b1;
    px(10'd799, 10'd0, 1'b1);
    line_ready = 1'b0;
    total++; if (rd_bank !== 1'b1 || line_ack !== 1'b1 || dut.pending !== 1'b0)
      $display("FAIL same_cycle got bank=%b ack=%b pend=%b exp 1 1 0", rd_bank, line_ack, dut.pending); else passed++;
    tick();
    px(10'd799, 10'd1, 1'b1);
    total++; if (underrun !== 1'b1 || rd_bank !== 1'b1)
      $display("FAIL same_cycle_next got u=%b bank=%b exp u=1 bank=1", underrun, rd_bank); else passed++;
  endtask

  task automatic test_reset_mid();
    int bad;
    pulse_ready();
    px(10'd799, 10'd2, 1'b1);
    pulse_ready();
    px(10'd799, 10'd3, 1'b1);
    pulse_ready();
    px(10'd300, 10'd4, 1'b1); tick(); tick();
    total++; if (pix_valid !== 1'b1 || pix_index !== 4'h1 || rd_bank !== 1'b1)
      $display("FAIL pre_reset got v=%b idx=%0h bank=%b exp 1 1 1", pix_valid, pix_index, rd_bank); else passed++;
    Reset_n = 1'b0; #1;
    total++; if ({pix_valid, pix_blank, rd_bank, line_ack, underrun} !== 5'b0 || pix_index !== 4'h0 || rd_addr !== 10'd0)
      $display("FAIL mid_reset_out got flags=%b idx=%0h addr=%0d exp 0", {pix_valid, pix_blank, rd_bank, line_ack, underrun}, pix_index, rd_addr); else passed++;
    total++; if (dut.state !== 2'd0 || dut.pending !== 1'b0)
      $display("FAIL mid_reset_state got st=%0d pend=%b exp 0 0", dut.state, dut.pending); else passed++;
    tick(); Reset_n = 1'b1; tick();
    bad = 0;
    for (int x = 301; x < 306; x++) begin
      px(10'(x), 10'd4, 1'b1); tick(); tick();
      if (pix_index !== 4'h3 || underrun !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL post_reset_bg got %0d bad pixels exp 0", bad); else passed++;
    px(10'd799, 10'd4, 1'b1);
    total++; if (underrun !== 1'b1 || rd_bank !== 1'b0)
      $display("FAIL post_reset_event got u=%b bank=%b exp u=1 bank=0", underrun, rd_bank); else passed++;
  endtask

`ifdef SCANLINE_UNDERRUN_CNT_EN
  task automatic test_count();
    Reset_n = 1'b0; tick(); Reset_n = 1'b1; tick();
    total++; if (underrun_count !== 16'd0) $display("FAIL cnt_reset got %0d exp 0", underrun_count); else passed++;
    for (int y = 5; y < 8; y++) begin px(10'd799, 10'(y), 1'b1); tick(); end
    total++; if (underrun_count !== 16'd3) $display("FAIL cnt_three got %0d exp 3", underrun_count); else passed++;
    force dut.underrun_count = 16'hFFFF; #1; release dut.underrun_count;
    px(10'd799, 10'd8, 1'b1); tick(); tick();
    total++; if (underrun_count !== 16'hFFFF) $display("FAIL cnt_sat got %0h exp ffff", underrun_count); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_idle_bg();
    test_swap();
    test_back_to_back();
    test_underrun();
    test_vblank();
    test_same_cycle();
    test_reset_mid();
`ifdef SCANLINE_UNDERRUN_CNT_EN
    test_count();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
